// File: rtl/qea_pkg.sv
// Shared definitions for the QEA host sequencer: FSM encoding, the fixed-point
// 1.0 constant and the legal qubit-count window.
package qea_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CTX,
        INIT_STATE,
        START,
        RUN,
        RD_REQ,
        RD_WAIT,
        RD_OUT,
        FINISH
    } qea_state_t;

    localparam int QBIT_MIN        = 2;
    // Two qubits are folded into the PE lanes of one row; the rest index rows.
    localparam int QBIT_ROW_OFFSET = 2;
    localparam int AMP_HALF_WIDTH  = 32;

    function automatic logic [AMP_HALF_WIDTH-1:0] fp_one(input int frac_bits);
        return AMP_HALF_WIDTH'(1) << frac_bits;
    endfunction

    function automatic bit qbit_in_range(input int qbit, input int addr_width);
        return (qbit >= QBIT_MIN) && (qbit <= addr_width + QBIT_ROW_OFFSET);
    endfunction

    function automatic int unsigned rows_minus_one(input int qbit);
        return (32'd1 << (qbit - QBIT_ROW_OFFSET)) - 32'd1;
    endfunction

endpackage

// File: rtl/qea_host_seq_if.sv
// Host-side bundle of the QEA sequencer: command, context stream, RAM ports,
// readout stream and status. The slave modport is the sequencer itself.
interface qea_host_seq_if #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6
);
    logic                                 i_cmd_go;
    logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num;
    logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num;
    logic                                 i_ctx_valid;
    logic                                 o_ctx_ready;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word;
    logic                                 o_ctx_en;
    logic                                 o_ctx_wea;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data;
    logic [PE_NUM-1:0]                    o_state_ena;
    logic [PE_NUM-1:0]                    o_state_wea;
    logic [STATE_ADDR_WIDTH-1:0]          o_state_addra;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina;
    logic                                 o_start;
    logic                                 i_complete;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout;
    logic                                 o_rd_valid;
    logic                                 i_rd_ready;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data;
    logic                                 o_busy;
    logic                                 o_done;
    logic                                 o_err;
    logic [31:0]                          o_exec_cycles;

    modport master (
        output i_cmd_go, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_word,
               i_complete, i_state_dout, i_rd_ready,
        input  o_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
               o_state_ena, o_state_wea, o_state_addra, o_state_dina, o_start,
               o_rd_valid, o_rd_data, o_busy, o_done, o_err, o_exec_cycles
    );

    modport slave (
        input  i_cmd_go, i_qbit_num, i_ins_num, i_ctx_valid, i_ctx_word,
               i_complete, i_state_dout, i_rd_ready,
        output o_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
               o_state_ena, o_state_wea, o_state_addra, o_state_dina, o_start,
               o_rd_valid, o_rd_data, o_busy, o_done, o_err, o_exec_cycles
    );

endinterface

// File: rtl/qea_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over count.
module qea_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/qea_host_seq.sv
// Host sequencer for the QEA: loads gate context, seeds the state vector to |0>,
// starts the engine, times the run and streams the resulting state rows out.
module qea_host_seq
    import qea_pkg::*;
#(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic          clk,
    input  logic          rst,
    qea_host_seq_if.slave bus
);

    localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
    localparam int CNT_W = GATE_CONTEXT_ADDR_WIDTH + 1;
    localparam logic [STATE_DATA_WIDTH-1:0] ONE_LANE =
        {fp_one(NUM_FRAC_BIT), {(STATE_DATA_WIDTH-AMP_HALF_WIDTH){1'b0}}};
    // Amplitude 1.0 of basis state |0> sits in the top PE lane of row 0.
    localparam logic [ROW_W-1:0] ROW0_INIT = {ONE_LANE, {(ROW_W-STATE_DATA_WIDTH){1'b0}}};

    qea_state_t                  state;
    logic [CNT_W-1:0]            ins_num;
    logic [CNT_W-1:0]            ctx_cnt;
    logic [STATE_ADDR_WIDTH-1:0] row;
    logic [STATE_ADDR_WIDTH-1:0] last_row;
    logic [MAX_QBIT_WIDTH-1:0]   qbit_in;
    logic                        cnt_clr;
    logic                        cnt_en;

    assign qbit_in = bus.i_qbit_num;
    // Clear on entry to START so the START cycle itself is the first counted cycle.
    assign cnt_clr = (state == INIT_STATE) && (row == last_row);
    assign cnt_en  = (state == START) || ((state == RUN) && !bus.i_complete);

    qea_sat_cnt #(.WIDTH(32)) u_exec_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (bus.o_exec_cycles)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            ins_num           <= '0;
            ctx_cnt           <= '0;
            row               <= '0;
            last_row          <= '0;
            bus.o_ctx_ready   <= 1'b0;
            bus.o_ctx_en      <= 1'b0;
            bus.o_ctx_wea     <= 1'b0;
            bus.o_ctx_addr    <= '0;
            bus.o_ctx_data    <= '0;
            bus.o_state_ena   <= '0;
            bus.o_state_wea   <= '0;
            bus.o_state_addra <= '0;
            bus.o_state_dina  <= '0;
            bus.o_start       <= 1'b0;
            bus.o_rd_valid    <= 1'b0;
            bus.o_rd_data     <= '0;
            bus.o_busy        <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_err         <= 1'b0;
        end else begin
            // NOTE: strobes and RAM ports fall back to zero every cycle and are
            // re-asserted only by the transition that needs them next cycle.
            bus.o_ctx_en      <= 1'b0;
            bus.o_ctx_wea     <= 1'b0;
            bus.o_ctx_addr    <= '0;
            bus.o_ctx_data    <= '0;
            bus.o_state_ena   <= '0;
            bus.o_state_wea   <= '0;
            bus.o_state_addra <= '0;
            bus.o_state_dina  <= '0;
            bus.o_start       <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_err         <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.i_cmd_go) begin
                        if (!qbit_in_range(int'(qbit_in), STATE_ADDR_WIDTH)) begin
                            bus.o_err <= 1'b1;
                        end else begin
                            ins_num     <= bus.i_ins_num;
                            last_row    <= STATE_ADDR_WIDTH'(rows_minus_one(int'(qbit_in)));
                            ctx_cnt     <= '0;
                            row         <= '0;
                            bus.o_busy  <= 1'b1;
                            if (bus.i_ins_num == '0) begin
                                state             <= INIT_STATE;
                                bus.o_state_ena   <= '1;
                                bus.o_state_wea   <= '1;
                                bus.o_state_dina  <= ROW0_INIT;
                            end else begin
                                state           <= LOAD_CTX;
                                bus.o_ctx_ready <= 1'b1;
                            end
                        end
                    end
                end

                LOAD_CTX: begin
                    if (bus.i_ctx_valid) begin
                        bus.o_ctx_en   <= 1'b1;
                        bus.o_ctx_wea  <= 1'b1;
                        bus.o_ctx_addr <= ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
                        bus.o_ctx_data <= bus.i_ctx_word;
                        ctx_cnt        <= ctx_cnt + CNT_W'(1);
                        if (ctx_cnt + CNT_W'(1) == ins_num) begin
                            state            <= INIT_STATE;
                            bus.o_ctx_ready  <= 1'b0;
                            bus.o_state_ena  <= '1;
                            bus.o_state_wea  <= '1;
                            bus.o_state_dina <= ROW0_INIT;
                        end
                    end
                end

                INIT_STATE: begin
                    if (row == last_row) begin
                        state       <= START;
                        bus.o_start <= 1'b1;
                    end else begin
                        row               <= row + STATE_ADDR_WIDTH'(1);
                        bus.o_state_ena   <= '1;
                        bus.o_state_wea   <= '1;
                        bus.o_state_addra <= row + STATE_ADDR_WIDTH'(1);
                    end
                end

                START: state <= RUN;

                RUN: begin
                    if (bus.i_complete) begin
                        state           <= RD_REQ;
                        row             <= '0;
                        bus.o_state_ena <= '1;
                    end
                end

                RD_REQ: state <= RD_WAIT;

                RD_WAIT: begin
                    state          <= RD_OUT;
                    bus.o_rd_valid <= 1'b1;
                    bus.o_rd_data  <= bus.i_state_dout;
                end

                RD_OUT: begin
                    if (bus.i_rd_ready) begin
                        bus.o_rd_valid <= 1'b0;
                        bus.o_rd_data  <= '0;
                        if (row == last_row) begin
                            state      <= FINISH;
                            bus.o_done <= 1'b1;
                        end else begin
                            state             <= RD_REQ;
                            row               <= row + STATE_ADDR_WIDTH'(1);
                            bus.o_state_ena   <= '1;
                            bus.o_state_addra <= row + STATE_ADDR_WIDTH'(1);
                        end
                    end
                end

                FINISH: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qea_host_seq.sv
// Randomized self-checking bench for qea_host_seq with a behavioural QEA/RAM model.
module tb_qea_host_seq;

    localparam int ROW_W = 256;

    logic clk;
    logic rst;

    qea_host_seq_if bus ();

    qea_host_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observations collected by the monitor.
    logic [15:0]      ctx_addr_q[$];
    logic [63:0]      ctx_data_q[$];
    logic [15:0]      st_addr_q[$];
    logic [ROW_W-1:0] st_data_q[$];
    bit               st_full_q[$];
    logic [ROW_W-1:0] rd_q[$];
    int start_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int done_rows = 0;

    // Rows the engine leaves in state RAM after a run; read back by the RAM model.
    logic [ROW_W-1:0] qea_rows[64];
    logic [63:0]      ctx_words[$];
    logic [ROW_W-1:0] row0_exp;

    int  base_ctx, base_st, base_rd, base_start, base_done, base_err;
    int  stall_seen;
    bit  stall_unstable;
    logic [31:0] exec_val;

    always @(posedge clk) begin
        if (bus.o_ctx_en && bus.o_ctx_wea) begin
            ctx_addr_q.push_back(bus.o_ctx_addr);
            ctx_data_q.push_back(bus.o_ctx_data);
        end
        if (|(bus.o_state_ena & bus.o_state_wea)) begin
            st_addr_q.push_back(bus.o_state_addra);
            st_data_q.push_back(bus.o_state_dina);
            st_full_q.push_back(bus.o_state_ena == 4'hF && bus.o_state_wea == 4'hF);
        end
        if (bus.o_rd_valid && bus.i_rd_ready) rd_q.push_back(bus.o_rd_data);
        if (bus.o_start) start_cnt <= start_cnt + 1;
        if (bus.o_err)   err_cnt   <= err_cnt + 1;
        if (bus.o_done) begin
            done_cnt  <= done_cnt + 1;
            done_rows <= rd_q.size();
        end
    end

    always @(posedge clk) begin
        if ((|bus.o_state_ena) && (bus.o_state_wea == '0) && (bus.o_state_addra < 16'd64))
            bus.i_state_dout <= qea_rows[bus.o_state_addra[5:0]];
    end

    function automatic bit outs_zero();
        return (|{bus.o_ctx_ready, bus.o_ctx_en, bus.o_ctx_wea, bus.o_ctx_addr, bus.o_ctx_data,
                  bus.o_state_ena, bus.o_state_wea, bus.o_state_addra, bus.o_state_dina,
                  bus.o_start, bus.o_rd_valid, bus.o_rd_data, bus.o_busy, bus.o_done,
                  bus.o_err, bus.o_exec_cycles}) === 1'b0;
    endfunction

    task automatic mark_bases();
        base_ctx   = ctx_addr_q.size();
        base_st    = st_addr_q.size();
        base_rd    = rd_q.size();
        base_start = start_cnt;
        base_done  = done_cnt;
        base_err   = err_cnt;
    endtask

    // Runs one complete job: go, context stream, wait for start, complete after
    // dly cycles, then drain the readout with an optional ready stall.
    task automatic do_job(input int qbit, input int ins, input int vmode, input int dly,
                          input int stall_row, input int stall_len, input bit go_in_run);
        int rows, idx, cyc;
        bit v, rdy, timeout;
        logic [ROW_W-1:0] held;
        rows = 1 << (qbit - 2);
        timeout = 0;
        stall_seen = 0;
        stall_unstable = 0;
        held = '0;
        mark_bases();
        ctx_words.delete();
        for (int i = 0; i < ins; i++) ctx_words.push_back({$urandom, $urandom});
        for (int r = 0; r < rows; r++)
            for (int w = 0; w < ROW_W / 32; w++) qea_rows[r][32*w +: 32] = $urandom;

        @(negedge clk);
        bus.i_cmd_go = 1'b1; bus.i_qbit_num = 6'(qbit); bus.i_ins_num = 17'(ins);
        @(negedge clk);
        bus.i_cmd_go = 1'b0;

        idx = 0; cyc = 0;
        while (idx < ins && cyc < 1000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.i_ctx_valid = v;
            bus.i_ctx_word  = ctx_words[idx];
            rdy = bus.o_ctx_ready;
            @(posedge clk);
            if (v && rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.i_ctx_valid = 1'b0;
        if (cyc >= 1000) timeout = 1;

        cyc = 0;
        while (!bus.o_start && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) timeout = 1;

        for (int k = 1; k <= dly; k++) begin
            @(posedge clk);
            #1;
            bus.i_cmd_go = go_in_run && (k == 3);
            bus.i_qbit_num = 6'd3;
            bus.i_ins_num  = 17'd0;
        end
        bus.i_cmd_go   = 1'b0;
        bus.i_complete = 1'b1;

        @(negedge clk);
        cyc = 0;
        while (done_cnt == base_done && cyc < 3000) begin
            rdy = 1'b0;
            if (bus.o_rd_valid) begin
                if (rd_q.size() - base_rd == stall_row && stall_seen < stall_len) begin
                    if (stall_seen == 0) held = bus.o_rd_data;
                    else if (bus.o_rd_data !== held) stall_unstable = 1;
                    stall_seen++;
                end else begin
                    rdy = 1'b1;
                end
            end
            bus.i_rd_ready = rdy;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.i_rd_ready = 1'b0;
        bus.i_complete = 1'b0;
        if (cyc >= 3000) timeout = 1;
        exec_val = bus.o_exec_cycles;

        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL job_timeout qbit=%0d ins=%0d: got timeout, expected completion", qbit, ins);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero output under reset, expected all zero");
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL idle_outputs: got nonzero output in idle, expected all zero");
        end
    endtask

    task automatic test_basic();
        do_job(4, 3, 0, 37, -1, 0, 1'b0);
        checks++;
        if (ctx_addr_q.size() - base_ctx != 3) begin
            errors++;
            $display("FAIL basic_ctx_count: got %0d, expected 3", ctx_addr_q.size() - base_ctx);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ctx_addr_q[base_ctx+i] !== 16'(i) || ctx_data_q[base_ctx+i] !== ctx_words[i]) begin
                    errors++;
                    $display("FAIL basic_ctx_%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                             i, ctx_addr_q[base_ctx+i], ctx_data_q[base_ctx+i], i, ctx_words[i]);
                end
            end
        end
        checks++;
        if (st_addr_q.size() - base_st != 4) begin
            errors++;
            $display("FAIL basic_init_count: got %0d, expected 4", st_addr_q.size() - base_st);
        end else begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (st_addr_q[base_st+r] !== 16'(r) || !st_full_q[base_st+r] ||
                    st_data_q[base_st+r] !== ((r == 0) ? row0_exp : '0)) begin
                    errors++;
                    $display("FAIL basic_init_row%0d: got addr=%0d full=%0d data=%h, expected addr=%0d full=1 data=%h",
                             r, st_addr_q[base_st+r], st_full_q[base_st+r], st_data_q[base_st+r],
                             r, (r == 0) ? row0_exp : '0);
                end
            end
        end
        checks++;
        if (start_cnt - base_start != 1) begin
            errors++;
            $display("FAIL basic_start: got %0d pulses, expected 1", start_cnt - base_start);
        end
        checks++;
        if (exec_val !== 32'd37) begin
            errors++;
            $display("FAIL basic_exec: got %0d, expected 37", exec_val);
        end
        checks++;
        if (done_cnt - base_done != 1 || err_cnt != base_err || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got done=%0d err=%0d busy=%0b, expected done=1 err=0 busy=0",
                     done_cnt - base_done, err_cnt - base_err, bus.o_busy);
        end
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (rd_q.size() - base_rd != 4 || rd_q[base_rd+r] !== qea_rows[r]) begin
                errors++;
                $display("FAIL basic_readout_row%0d: got count=%0d, expected count=4 data=%h",
                         r, rd_q.size() - base_rd, qea_rows[r]);
            end
        end
    endtask

    task automatic test_ctx_toggle();
        do_job(3, 5, 1, 10, -1, 0, 1'b0);
        checks++;
        if (ctx_addr_q.size() - base_ctx != 5) begin
            errors++;
            $display("FAIL toggle_ctx_count: got %0d, expected 5", ctx_addr_q.size() - base_ctx);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (ctx_addr_q[base_ctx+i] !== 16'(i) || ctx_data_q[base_ctx+i] !== ctx_words[i]) begin
                    errors++;
                    $display("FAIL toggle_ctx_%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                             i, ctx_addr_q[base_ctx+i], ctx_data_q[base_ctx+i], i, ctx_words[i]);
                end
            end
        end
    endtask

    task automatic test_exec_cycles();
        for (int n = 0; n < 2; n++) begin
            int d;
            d = $urandom_range(1, 60);
            do_job(2, 0, 0, d, -1, 0, 1'b0);
            checks++;
            if (exec_val !== 32'(d)) begin
                errors++;
                $display("FAIL exec_cycles_%0d: got %0d, expected %0d", n, exec_val, d);
            end
        end
    endtask

    task automatic test_rd_stall();
        do_job(4, 1, 0, 8, 2, 5, 1'b0);
        checks++;
        if (stall_seen != 5 || stall_unstable) begin
            errors++;
            $display("FAIL stall_hold: got stall_cycles=%0d unstable=%0b, expected 5 and 0",
                     stall_seen, stall_unstable);
        end
        checks++;
        if (rd_q.size() - base_rd != 4 || done_rows - base_rd != 4) begin
            errors++;
            $display("FAIL stall_rows: got rows=%0d rows_at_done=%0d, expected 4 and 4",
                     rd_q.size() - base_rd, done_rows - base_rd);
        end else begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (rd_q[base_rd+r] !== qea_rows[r]) begin
                    errors++;
                    $display("FAIL stall_row%0d: got %h, expected %h", r, rd_q[base_rd+r], qea_rows[r]);
                end
            end
        end
    endtask

    task automatic test_bad_qbit();
        int bad_q[2];
        bad_q = '{1, 19};
        for (int n = 0; n < 2; n++) begin
            mark_bases();
            @(negedge clk);
            bus.i_cmd_go = 1'b1; bus.i_qbit_num = 6'(bad_q[n]); bus.i_ins_num = 17'd2;
            bus.i_ctx_valid = 1'b1; bus.i_ctx_word = {$urandom, $urandom};
            @(negedge clk);
            bus.i_cmd_go = 1'b0;
            repeat (6) @(negedge clk);
            bus.i_ctx_valid = 1'b0;
            checks++;
            if (err_cnt - base_err != 1 || ctx_addr_q.size() != base_ctx ||
                st_addr_q.size() != base_st || bus.o_busy !== 1'b0 || bus.o_ctx_ready !== 1'b0) begin
                errors++;
                $display("FAIL bad_qbit_%0d: got err=%0d ctx_wr=%0d st_wr=%0d busy=%0b, expected err=1 ctx_wr=0 st_wr=0 busy=0",
                         bad_q[n], err_cnt - base_err, ctx_addr_q.size() - base_ctx,
                         st_addr_q.size() - base_st, bus.o_busy);
            end
        end
    endtask

    task automatic test_go_in_run();
        do_job(3, 2, 0, 12, -1, 0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (start_cnt - base_start != 1 || done_cnt - base_done != 1 || err_cnt != base_err ||
            bus.o_busy !== 1'b0 || rd_q.size() - base_rd != 2) begin
            errors++;
            $display("FAIL go_in_run: got start=%0d done=%0d err=%0d busy=%0b rows=%0d, expected 1 1 0 0 2",
                     start_cnt - base_start, done_cnt - base_done, err_cnt - base_err,
                     bus.o_busy, rd_q.size() - base_rd);
        end
    endtask

    task automatic test_reset_mid_init();
        @(negedge clk);
        bus.i_cmd_go = 1'b1; bus.i_qbit_num = 6'd6; bus.i_ins_num = 17'd0;
        @(negedge clk);
        bus.i_cmd_go = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_state_ena !== 4'hF || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_init_active: got ena=%h busy=%0b, expected ena=f busy=1",
                     bus.o_state_ena, bus.o_busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL mid_init_reset: got nonzero output during reset, expected all zero");
        end
        @(negedge clk);
        rst = 1'b0;
        do_job(3, 2, 0, 9, -1, 0, 1'b0);
        checks++;
        if (start_cnt - base_start != 1 || done_cnt - base_done != 1 || exec_val !== 32'd9 ||
            ctx_addr_q.size() - base_ctx != 2 || st_addr_q.size() - base_st != 2 ||
            rd_q.size() - base_rd != 2) begin
            errors++;
            $display("FAIL post_reset_job: got start=%0d done=%0d exec=%0d ctx=%0d st=%0d rows=%0d, expected 1 1 9 2 2 2",
                     start_cnt - base_start, done_cnt - base_done, exec_val,
                     ctx_addr_q.size() - base_ctx, st_addr_q.size() - base_st, rd_q.size() - base_rd);
        end else begin
            checks++;
            if (rd_q[base_rd] !== qea_rows[0] || rd_q[base_rd+1] !== qea_rows[1]) begin
                errors++;
                $display("FAIL post_reset_rows: got %h, expected %h", rd_q[base_rd], qea_rows[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            int q, ins, rows, d;
            q    = $urandom_range(2, 5);
            ins  = $urandom_range(0, 6);
            rows = 1 << (q - 2);
            d    = $urandom_range(1, 40);
            do_job(q, ins, $urandom_range(0, 2), d, $urandom_range(0, rows - 1),
                   $urandom_range(0, 4), 1'b0);
            checks++;
            if (exec_val !== 32'(d) || ctx_addr_q.size() - base_ctx != ins ||
                st_addr_q.size() - base_st != rows || rd_q.size() - base_rd != rows) begin
                errors++;
                $display("FAIL random_%0d_counts: got exec=%0d ctx=%0d st=%0d rows=%0d, expected %0d %0d %0d %0d",
                         n, exec_val, ctx_addr_q.size() - base_ctx, st_addr_q.size() - base_st,
                         rd_q.size() - base_rd, d, ins, rows, rows);
            end else begin
                bit bad;
                bad = 0;
                for (int i = 0; i < ins; i++)
                    if (ctx_addr_q[base_ctx+i] !== 16'(i) || ctx_data_q[base_ctx+i] !== ctx_words[i]) bad = 1;
                for (int r = 0; r < rows; r++) begin
                    if (st_addr_q[base_st+r] !== 16'(r)) bad = 1;
                    if (st_data_q[base_st+r] !== ((r == 0) ? row0_exp : '0)) bad = 1;
                    if (rd_q[base_rd+r] !== qea_rows[r]) bad = 1;
                end
                checks++;
                if (bad || stall_unstable) begin
                    errors++;
                    $display("FAIL random_%0d_data: got content mismatch=%0b unstable=%0b, expected 0 and 0",
                             n, bad, stall_unstable);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_cmd_go = 1'b0;
        bus.i_qbit_num = '0;
        bus.i_ins_num = '0;
        bus.i_ctx_valid = 1'b0;
        bus.i_ctx_word = '0;
        bus.i_complete = 1'b0;
        bus.i_rd_ready = 1'b0;
        row0_exp = '0;
        row0_exp[ROW_W-1 -: 64] = 64'h40000000_00000000;
        for (int r = 0; r < 64; r++) qea_rows[r] = '0;

        test_reset();
        test_basic();
        test_ctx_toggle();
        test_exec_cycles();
        test_rd_stall();
        test_bad_qbit();
        test_go_in_run();
        test_reset_mid_init();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
